// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I decode controller: opcodes, control field codes
// and the Decode->Execute control bundle.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   localparam logic [1:0] JMP_NONE = 2'b00;
   localparam logic [1:0] JMP_JAL  = 2'b01;
   localparam logic [1:0] JMP_JALR = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_R   = 2'b10;
   localparam logic [1:0] ALU_I   = 2'b11;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_BEQ  = 3'b001;
   localparam logic [2:0] BR_BNE  = 3'b010;
   localparam logic [2:0] BR_BLT  = 3'b011;
   localparam logic [2:0] BR_BGE  = 3'b100;
   localparam logic [2:0] BR_BLTU = 3'b101;
   localparam logic [2:0] BR_BGEU = 3'b110;

   localparam logic [1:0] MD_NONE = 2'b00;
   localparam logic [1:0] MD_MUL  = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic       lui;
      logic       auipc;
      logic [1:0] result_src;
      logic [1:0] jump;
      logic [1:0] alu_op;
      logic [2:0] branch;
      logic       illegal;
      logic [1:0] md_op;
   } ctrl_t;

   // Unsupported branch func3 values (010, 011) map to BR_NONE.
   function automatic logic [2:0] branch_sel(input logic [2:0] f3);
      case (f3)
         3'b000:  return BR_BEQ;
         3'b001:  return BR_BNE;
         3'b100:  return BR_BLT;
         3'b101:  return BR_BGE;
         3'b110:  return BR_BLTU;
         3'b111:  return BR_BGEU;
         default: return BR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multi-cycle MUL/DIV occupancy tracker: counts an M op through Execute, stalling
// the front end until the final cycle, where it pulses done.
module md_sequencer
   import riscv_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [1:0] md_op,
   output logic       md_stall,
   output logic       md_done
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   assign md_stall = (state_reg == S_BUSY) && (cnt_reg != '0);
   assign md_done  = (state_reg == S_BUSY) && (cnt_reg == '0);

   // The done cycle does not stall, so a following M op can load straight into BUSY.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (md_stall) begin
         cnt_next = cnt_reg - CNT_W'(1);
      end else if (load && (md_op != MD_NONE)) begin
         state_next = S_BUSY;
         cnt_next   = (md_op == MD_DIV) ? DIV_CNT : MUL_CNT;
      end else begin
         state_next = S_IDLE;
         cnt_next   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// RV32I Decode-stage controller with the Decode->Execute control register.
// Define M_EXT_EN to build M-extension decode and the multi-cycle sequencer.
module decode_ctrl_pipe
   import riscv_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       flushE,
   output logic [2:0] immSrcD,
   output logic       illegalD,
   output logic       regWriteE,
   output logic       memWriteE,
   output logic       ALUSrcE,
   output logic       luiE,
   output logic       auipcE,
   output logic [1:0] resultSrcE,
   output logic [1:0] jumpE,
   output logic [1:0] ALUOpE,
   output logic [2:0] branchE,
   output logic       illegalE,
   output logic [1:0] mdOpE,
   output logic       mdStall,
   output logic       mdDoneE
);

   if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_lat_check
      $error("MUL_LAT and DIV_LAT must be at least 1");
   end

   ctrl_t      ctrl_d;
   ctrl_t      ctrl_e_reg;
   logic [2:0] imm_src_d;
   logic       md_stall;
   logic       md_done;

   always_comb begin
      ctrl_d    = '0;
      imm_src_d = IMM_I;
      case (op)
         OP_R: begin
            if (func7 == F7_MULDIV) begin
`ifdef M_EXT_EN
               ctrl_d.reg_write = 1'b1;
               ctrl_d.alu_op    = ALU_R;
               ctrl_d.md_op     = func3[2] ? MD_DIV : MD_MUL;
`else
               ctrl_d.illegal   = 1'b1;
`endif
            end else begin
               ctrl_d.reg_write = 1'b1;
               ctrl_d.alu_op    = ALU_R;
            end
         end
         OP_I: begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_op    = ALU_I;
         end
         OP_S: begin
            ctrl_d.mem_write = 1'b1;
            ctrl_d.alu_src   = 1'b1;
            imm_src_d        = IMM_S;
         end
         OP_B: begin
            ctrl_d.alu_op  = ALU_SUB;
            ctrl_d.branch  = branch_sel(func3);
            ctrl_d.illegal = (branch_sel(func3) == BR_NONE);
            imm_src_d      = IMM_B;
         end
         OP_LOAD: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.result_src = RES_MEM;
         end
         OP_LUI: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.lui        = 1'b1;
            ctrl_d.result_src = RES_IMM;
            imm_src_d         = IMM_U;
         end
         OP_AUIPC: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.auipc      = 1'b1;
            ctrl_d.alu_op     = ALU_ADD;
            ctrl_d.result_src = RES_ALU;
            imm_src_d         = IMM_U;
         end
         OP_JAL: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.jump       = JMP_JAL;
            ctrl_d.result_src = RES_PC4;
            imm_src_d         = IMM_J;
         end
         OP_JALR: begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.jump       = JMP_JALR;
            ctrl_d.result_src = RES_PC4;
            imm_src_d         = IMM_I;
         end
         default: ctrl_d.illegal = 1'b1;
      endcase
   end

`ifdef M_EXT_EN
   logic load_e;

   // A load happens only when E is neither held nor flushed.
   assign load_e = !md_stall && !flushE;

   md_sequencer #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_md_sequencer (
      .clk      (clk),
      .rst      (rst),
      .load     (load_e),
      .md_op    (ctrl_d.md_op),
      .md_stall (md_stall),
      .md_done  (md_done)
   );
`else
   assign md_stall = 1'b0;
   assign md_done  = 1'b0;
`endif

   // A running M op holds E even over a flush request.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_e_reg <= '0;
      end else if (md_stall) begin
         ctrl_e_reg <= ctrl_e_reg;
      end else if (flushE) begin
         ctrl_e_reg <= '0;
      end else begin
         ctrl_e_reg <= ctrl_d;
      end
   end

   assign immSrcD    = imm_src_d;
   assign illegalD   = ctrl_d.illegal;
   assign regWriteE  = ctrl_e_reg.reg_write;
   assign memWriteE  = ctrl_e_reg.mem_write;
   assign ALUSrcE    = ctrl_e_reg.alu_src;
   assign luiE       = ctrl_e_reg.lui;
   assign auipcE     = ctrl_e_reg.auipc;
   assign resultSrcE = ctrl_e_reg.result_src;
   assign jumpE      = ctrl_e_reg.jump;
   assign ALUOpE     = ctrl_e_reg.alu_op;
   assign branchE    = ctrl_e_reg.branch;
   assign illegalE   = ctrl_e_reg.illegal;
   assign mdOpE      = ctrl_e_reg.md_op;
   assign mdStall    = md_stall;
   assign mdDoneE    = md_done;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe; M-extension scenarios run when M_EXT_EN is defined.
`timescale 1ns/1ps
module tb_decode_ctrl_pipe;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       flushE;
   logic [2:0] immSrcD;
   logic       illegalD;
   logic       regWriteE, memWriteE, ALUSrcE, luiE, auipcE;
   logic [1:0] resultSrcE, jumpE, ALUOpE;
   logic [2:0] branchE;
   logic       illegalE;
   logic [1:0] mdOpE;
   logic       mdStall, mdDoneE;

   decode_ctrl_pipe #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .func3      (func3),
      .func7      (func7),
      .flushE     (flushE),
      .immSrcD    (immSrcD),
      .illegalD   (illegalD),
      .regWriteE  (regWriteE),
      .memWriteE  (memWriteE),
      .ALUSrcE    (ALUSrcE),
      .luiE       (luiE),
      .auipcE     (auipcE),
      .resultSrcE (resultSrcE),
      .jumpE      (jumpE),
      .ALUOpE     (ALUOpE),
      .branchE    (branchE),
      .illegalE   (illegalE),
      .mdOpE      (mdOpE),
      .mdStall    (mdStall),
      .mdDoneE    (mdDoneE)
   );

   always #5 clk = ~clk;

   // E vector order: regWrite memWrite ALUSrc lui auipc resultSrc[2] jump[2] ALUOp[2] branch[3] illegal mdOp[2]
   logic [16:0] e_vec;
   assign e_vec = {regWriteE, memWriteE, ALUSrcE, luiE, auipcE, resultSrcE, jumpE,
                   ALUOpE, branchE, illegalE, mdOpE};

   localparam logic [16:0] ALL_MASK    = 17'h1FFFF;
   localparam logic [16:0] BR_ILL_MASK = 17'b0_0_0_0_0_00_00_00_111_1_00;
   localparam logic [16:0] V_ADD       = 17'b1_0_0_0_0_00_00_10_000_0_00;
   localparam logic [16:0] V_LUI       = 17'b1_0_0_1_0_11_00_00_000_0_00;
   localparam logic [16:0] V_ZERO      = 17'b0;

   typedef struct {
      logic [16:0] vec;
      logic [16:0] mask;
      string       name;
   } exp_t;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [16:0] vec;
      logic [2:0]  imm;
      logic        ill;
      string       name;
   } dec_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
      op = o;
      func3 = f3;
      func7 = f7;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [16:0] v, input logic [16:0] m, input string n);
      exp_t e;
      e.vec  = v;
      e.mask = m;
      e.name = n;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      flushE = 1'b0;
      drive(7'b0110111, 3'b000, 7'b0000000);
      tick();
      tick();
      checks++;
      if (e_vec !== V_ZERO) begin
         failures++;
         $display("FAIL reset_e: got %b required %b", e_vec, V_ZERO);
      end
      checks++;
      if ({mdStall, mdDoneE} !== 2'b00) begin
         failures++;
         $display("FAIL reset_md: got stall=%b done=%b required 0 0", mdStall, mdDoneE);
      end
      $display("reset: e=%b stall=%b done=%b", e_vec, mdStall, mdDoneE);
      rst = 1'b0;
      // LUI sits in D, so the first post-reset edge loads it.
      push(V_LUI, ALL_MASK, "LUI_after_reset");
      tick();
      e = sb_q.pop_front();
      checks++;
      if (e_vec !== e.vec) begin
         failures++;
         $display("FAIL %s: got %b required %b", e.name, e_vec, e.vec);
      end
   endtask

   task automatic test_decode();
      dec_t tbl[11];
      exp_t e;
      tbl[0]  = '{7'b0110011, 3'b000, 7'b0000000, 17'b1_0_0_0_0_00_00_10_000_0_00, 3'b000, 1'b0, "ADD"};
      tbl[1]  = '{7'b0110011, 3'b000, 7'b0100000, 17'b1_0_0_0_0_00_00_10_000_0_00, 3'b000, 1'b0, "SUB"};
      tbl[2]  = '{7'b0010011, 3'b000, 7'b0000000, 17'b1_0_0_0_0_00_00_11_000_0_00, 3'b000, 1'b0, "ADDI"};
      tbl[3]  = '{7'b0100011, 3'b010, 7'b0000000, 17'b0_1_1_0_0_00_00_00_000_0_00, 3'b001, 1'b0, "SW"};
      tbl[4]  = '{7'b0000011, 3'b010, 7'b0000000, 17'b1_0_1_0_0_01_00_00_000_0_00, 3'b000, 1'b0, "LW"};
      tbl[5]  = '{7'b0110111, 3'b000, 7'b0000000, 17'b1_0_0_1_0_11_00_00_000_0_00, 3'b100, 1'b0, "LUI"};
      tbl[6]  = '{7'b0010111, 3'b000, 7'b0000000, 17'b1_0_1_0_1_00_00_00_000_0_00, 3'b100, 1'b0, "AUIPC"};
      tbl[7]  = '{7'b1101111, 3'b000, 7'b0000000, 17'b1_0_0_0_0_10_01_00_000_0_00, 3'b011, 1'b0, "JAL"};
      tbl[8]  = '{7'b1100111, 3'b000, 7'b0000000, 17'b1_0_1_0_0_10_10_00_000_0_00, 3'b000, 1'b0, "JALR"};
      tbl[9]  = '{7'b1100011, 3'b000, 7'b0000000, 17'b0_0_0_0_0_00_00_01_001_0_00, 3'b010, 1'b0, "BEQ"};
      tbl[10] = '{7'b1111111, 3'b000, 7'b0000000, 17'b0_0_0_0_0_00_00_00_000_1_00, 3'b000, 1'b1, "BAD_OP"};
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].op, tbl[i].f3, tbl[i].f7);
         checks++;
         if (illegalD !== tbl[i].ill) begin
            failures++;
            $display("FAIL illegalD_%s: got %b required %b", tbl[i].name, illegalD, tbl[i].ill);
         end
         checks++;
         if (immSrcD !== tbl[i].imm) begin
            failures++;
            $display("FAIL immSrcD_%s: got %b required %b", tbl[i].name, immSrcD, tbl[i].imm);
         end
         push(tbl[i].vec, ALL_MASK, tbl[i].name);
         tick();
         e = sb_q.pop_front();
         checks++;
         if (e_vec !== e.vec) begin
            failures++;
            $display("FAIL E_%s: got %b required %b", e.name, e_vec, e.vec);
         end
         $display("decode %s: immSrcD=%b illegalD=%b e=%b", tbl[i].name, immSrcD, illegalD, e_vec);
      end
   endtask

   task automatic test_branches();
      logic [2:0] f3s [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
      logic [2:0] brs [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000, 3'b000};
      logic       ills[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         drive(7'b1100011, f3s[i], 7'b0000000);
         checks++;
         if (illegalD !== ills[i]) begin
            failures++;
            $display("FAIL br_illegalD f3=%b: got %b required %b", f3s[i], illegalD, ills[i]);
         end
         if (ills[i])
            push({5'b0, 2'b00, 2'b00, 2'b00, brs[i], 1'b1, 2'b00}, BR_ILL_MASK, "BR_BAD");
         else
            push({5'b0, 2'b00, 2'b00, 2'b01, brs[i], 1'b0, 2'b00}, ALL_MASK, "BR");
         tick();
         e = sb_q.pop_front();
         checks++;
         if ((e_vec & e.mask) !== (e.vec & e.mask)) begin
            failures++;
            $display("FAIL %s f3=%b: got %b required %b", e.name, f3s[i], e_vec, e.vec);
         end
         $display("branch f3=%b: branchE=%b illegalE=%b", f3s[i], branchE, illegalE);
      end
   endtask

   task automatic test_flush_idle();
      exp_t e;
      drive(7'b0110111, 3'b000, 7'b0000000);
      push(V_LUI, ALL_MASK, "LUI_pre_flush");
      tick();
      e = sb_q.pop_front();
      checks++;
      if (e_vec !== e.vec) begin
         failures++;
         $display("FAIL %s: got %b required %b", e.name, e_vec, e.vec);
      end
      flushE = 1'b1;
      drive(7'b0110011, 3'b000, 7'b0000000);
      push(V_ZERO, ALL_MASK, "flush_bubble");
      tick();
      flushE = 1'b0;
      e = sb_q.pop_front();
      checks++;
      if (e_vec !== e.vec) begin
         failures++;
         $display("FAIL %s: got %b required %b", e.name, e_vec, e.vec);
      end
      $display("flush idle: e=%b", e_vec);
   endtask

`ifndef M_EXT_EN
   task automatic test_mext_disabled();
      logic [2:0] f3s[2] = '{3'b000, 3'b100};
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(7'b0110011, f3s[i], 7'b0000001);
         checks++;
         if (illegalD !== 1'b1) begin
            failures++;
            $display("FAIL mext_off_illegalD f3=%b: got %b required 1", f3s[i], illegalD);
         end
         push(17'b0_0_0_0_0_00_00_00_000_1_00, ALL_MASK, "MEXT_OFF");
         tick();
         e = sb_q.pop_front();
         checks++;
         if (e_vec !== e.vec) begin
            failures++;
            $display("FAIL %s f3=%b: got %b required %b", e.name, f3s[i], e_vec, e.vec);
         end
         checks++;
         if ({mdStall, mdDoneE} !== 2'b00) begin
            failures++;
            $display("FAIL mext_off_md: got stall=%b done=%b required 0 0", mdStall, mdDoneE);
         end
         $display("mext off f3=%b: e=%b stall=%b", f3s[i], e_vec, mdStall);
      end
   endtask
`else
   // Entered with an M op just loaded in E and the next instruction already queued behind it.
   task automatic md_run(input int lat, input logic flush_mid, input string tag);
      for (int c = 1; c <= lat; c++) begin
         flushE = flush_mid && (c < lat);
         checks++;
         if (mdStall !== (c < lat)) begin
            failures++;
            $display("FAIL %s_stall c=%0d: got %b required %b", tag, c, mdStall, (c < lat));
         end
         checks++;
         if (mdDoneE !== (c == lat)) begin
            failures++;
            $display("FAIL %s_done c=%0d: got %b required %b", tag, c, mdDoneE, (c == lat));
         end
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_hold c=%0d: scoreboard empty", tag, c);
         end else if (e_vec !== sb_q[0].vec) begin
            failures++;
            $display("FAIL %s_hold c=%0d: got %b required %b", tag, c, e_vec, sb_q[0].vec);
         end
         if (c == lat && sb_q.size() != 0) void'(sb_q.pop_front());
         tick();
      end
      flushE = 1'b0;
      $display("md %s: %0d cycles complete", tag, lat);
   endtask

   task automatic test_mul();
      exp_t e;
      drive(7'b0110011, 3'b000, 7'b0000001);
      push(17'b1_0_0_0_0_00_00_10_000_0_01, ALL_MASK, "MUL");
      tick();
      drive(7'b0110011, 3'b000, 7'b0000000);
      push(V_ADD, ALL_MASK, "ADD_after_MUL");
      md_run(MUL_LAT, 1'b0, "MUL");
      e = sb_q.pop_front();
      checks++;
      if (e_vec !== e.vec || mdStall !== 1'b0 || mdDoneE !== 1'b0) begin
         failures++;
         $display("FAIL %s: got %b stall=%b done=%b required %b 0 0", e.name, e_vec, mdStall, mdDoneE, e.vec);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      drive(7'b0110011, 3'b100, 7'b0000001);
      push(17'b1_0_0_0_0_00_00_10_000_0_10, ALL_MASK, "DIV");
      tick();
      drive(7'b0110011, 3'b000, 7'b0000001);
      push(17'b1_0_0_0_0_00_00_10_000_0_01, ALL_MASK, "MUL_after_DIV");
      md_run(DIV_LAT, 1'b0, "DIV");
      drive(7'b0110011, 3'b000, 7'b0000000);
      push(V_ADD, ALL_MASK, "ADD_after_MUL2");
      md_run(MUL_LAT, 1'b0, "MUL2");
      e = sb_q.pop_front();
      checks++;
      if (e_vec !== e.vec) begin
         failures++;
         $display("FAIL %s: got %b required %b", e.name, e_vec, e.vec);
      end
   endtask

   task automatic test_flush_busy();
      exp_t e;
      drive(7'b0110011, 3'b001, 7'b0000001);
      push(17'b1_0_0_0_0_00_00_10_000_0_01, ALL_MASK, "MULH");
      tick();
      drive(7'b0110011, 3'b000, 7'b0000000);
      push(V_ADD, ALL_MASK, "ADD_after_flushed_MUL");
      md_run(MUL_LAT, 1'b1, "MUL_flush");
      e = sb_q.pop_front();
      checks++;
      if (e_vec !== e.vec) begin
         failures++;
         $display("FAIL %s: got %b required %b", e.name, e_vec, e.vec);
      end
   endtask

   task automatic test_reset_mid_div();
      logic done_seen = 1'b0;
      drive(7'b0110011, 3'b101, 7'b0000001);
      tick();
      drive(7'b0110011, 3'b000, 7'b0000000);
      for (int c = 1; c < 10; c++) begin
         checks++;
         if (mdStall !== 1'b1) begin
            failures++;
            $display("FAIL rst_div_stall c=%0d: got %b required 1", c, mdStall);
         end
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (e_vec !== V_ZERO || mdStall !== 1'b0 || mdDoneE !== 1'b0) begin
         failures++;
         $display("FAIL rst_div_abort: got %b stall=%b done=%b required all 0", e_vec, mdStall, mdDoneE);
      end
      for (int c = 0; c < DIV_LAT + 8; c++) begin
         if (mdDoneE === 1'b1 || mdStall === 1'b1) done_seen = 1'b1;
         tick();
      end
      checks++;
      if (done_seen !== 1'b0) begin
         failures++;
         $display("FAIL rst_div_no_done: got md activity=1 required 0");
      end
      $display("reset mid DIV: e=%b md activity=%b", e_vec, done_seen);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      flushE = 1'b0;
      op = 7'b0;
      func3 = 3'b0;
      func7 = 7'b0;
      test_reset();
      test_decode();
      test_branches();
      test_flush_idle();
`ifndef M_EXT_EN
      test_mext_disabled();
`else
      test_mul();
      test_back_to_back();
      test_flush_busy();
      test_reset_mid_div();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered, parametrised decode controller for the 5-stage RV32I pipeline. It decodes opcode/func3/func7 in the Decode stage and drives the immediate-select combinationally. It holds the Decode→Execute control register with flush and hold semantics. It adds the full branch set, AUIPC, illegal-instruction detection and an optional multi-cycle M-extension sequencer that stalls the front end.

## Interface
- MUL_LAT, 3: Execute cycles a MUL* occupies (≥1).
- DIV_LAT, 32: Execute cycles a DIV*/REM* occupies (≥1).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; one clock only.
- op  in  7  instruction[6:0] in D.
- func3  in  3  instruction[14:12] in D.
- func7  in  7  instruction[31:25] in D.
- flushE  in  1  from hazard unit: load a bubble into E.
- immSrcD  out  3  combinational immediate select: 000 I, 001 S, 010 B, 011 J, 100 U.
- illegalD  out  1  combinational: unsupported encoding in D.
- regWriteE, memWriteE, ALUSrcE, luiE, auipcE  out  1 each  registered controls.
- resultSrcE  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm.
- jumpE  out  2  00 none, 01 JAL, 10 JALR.
- ALUOpE  out  2  00 add, 01 sub/compare, 10 R-type, 11 I-type.
- branchE  out  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU.
- illegalE  out  1  registered illegalD.
- mdOpE  out  2  00 none, 01 mul, 10 div/rem.
- mdStall  out  1  hold F, D and E this cycle.
- mdDoneE  out  1  M result valid in E this cycle.

## Operation
- Decode: R 0110011, I 0010011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, LOAD 0000011, JALR 1100111. Any other opcode sets illegalD=1 and decodes to all-zero controls.
- R-type and I-type set ALUOp 10/11 with regWrite. S-type sets memWrite, ALUSrc, imm 001. LOAD sets resultSrc 01, ALUSrc, regWrite.
- LUI: resultSrc 11, imm 100, luiD=1, regWrite. AUIPC: imm 100, ALUSrc, auipcD=1, ALUOp 00, resultSrc 00, regWrite.
- JAL: jump 01, imm 011, resultSrc 10, regWrite. JALR: jump 10, imm 000, ALUSrc, resultSrc 10, regWrite.
- B-type: ALUOp 01, imm 010, branch per func3 (000→001, 001→010, 100→011, 101→100, 110→101, 111→110). func3 010/011 sets illegalD and gives branch 000.
- M op (see Configuration): R-type with func7=0000001. func3[2]=0 gives mdOp 01; func3[2]=1 gives mdOp 10. regWrite=1, ALUOp 10.
- E-register update priority:
  1. rst: all E outputs 0.
  2. mdStall: hold all E outputs. flushE is ignored.
  3. flushE: all E outputs 0.
  4. Otherwise: load the decoded D values.
- Sequencer FSM has two states, IDLE and BUSY, with counter cnt of width $clog2(max(MUL_LAT,DIV_LAT))+1.
  - Any load with mdOp≠00 moves to BUSY with cnt=LAT−1. LAT is MUL_LAT or DIV_LAT per mdOp.
  - In BUSY with cnt≠0: mdStall=1 and cnt decrements.
  - In BUSY with cnt=0: mdStall=0 and mdDoneE=1. Next state is IDLE, unless a new M op loads this same cycle, which re-enters BUSY.
  - A bubble or non-M load leaves the FSM in IDLE.

## Timing
- immSrcD and illegalD: 0-cycle combinational.
- All E outputs: 1-cycle latency from D.
- An M op occupies E for exactly LAT cycles: mdStall is high for LAT−1 cycles, then mdDoneE pulses for 1 cycle. LAT=1 never stalls.
- Reset values: every registered output 0, FSM IDLE, cnt 0, mdStall 0, mdDoneE 0.
- Reset asserted mid-BUSY aborts the op; the next cycle is IDLE with no mdDoneE.

## Configuration
- M_EXT_EN defined: M decode, mdOpE, and the sequencer are present.
- M_EXT_EN undefined: func7=0000001 R-type sets illegalD and decodes to all-zero controls. mdOpE, mdStall and mdDoneE are tied 0, and no FSM is built.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode constants;
  - branch, immSrc, resultSrc, jump, ALUOp and mdOp encodings.
- Sub-module md_sequencer holds the FSM, counter and latency selection, and is instantiated only under M_EXT_EN.

## Test plan
- Decode sweep: each legal opcode, then the next clock → E outputs match the encodings above. op=1111111 → illegalD=1, all controls 0.
- Branches: func3 000,001,100,101,110,111 → branchE 001..110. func3 010 → branchE=000, illegalE=1.
- MUL with MUL_LAT=3: mdStall high for 2 cycles, mdDoneE in cycle 3, E held throughout; the next instruction loads in cycle 4.
- DIV immediately followed by MUL with DIV_LAT=32: 31 stall cycles, then mdDoneE, then the MUL enters BUSY with cnt=2 and no idle gap.
- flushE asserted during BUSY → ignored, M op completes. flushE when idle → all E outputs 0 next cycle.
- rst during DIV cycle 10 → next cycle all outputs 0, mdStall=0, mdDoneE never asserted.
